// File: rtl/id_hazard_ctrl.sv
// ID-stage interlock controller. Tracks the destination registers of the
// instructions in EX, MEM and WB, stalls IF/ID on read-after-write hazards,
// injects bubbles into EX and, when a forwarding datapath exists, selects
// the bypass source for each EX operand.
module id_hazard_ctrl #(
    parameter int unsigned FORWARD = 1,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_id_valid,
    input  logic [4:0]       i_id_rs,
    input  logic [4:0]       i_id_rt,
    input  logic             i_id_use_rs,
    input  logic             i_id_use_rt,
    input  logic             i_id_reg_write,
    input  logic [4:0]       i_id_dest,
    input  logic             i_id_is_load,
    input  logic             i_flush,
    output logic             o_stall,
    output logic             o_bubble,
    output logic [1:0]       o_fwd_a,
    output logic [1:0]       o_fwd_b,
    output logic [CNT_W-1:0] o_stall_cnt
);

    // Bypass source encoding seen by the EX operand muxes.
    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_MEM = 2'd1;  // EX/MEM pipeline register
    localparam logic [1:0] FWD_WB  = 2'd2;  // MEM/WB pipeline register
    localparam logic [1:0] FWD_WBV = 2'd3;  // value being written back

    // One in-flight instruction as far as hazards are concerned.
    typedef struct packed {
        logic       v;
        logic       we;
        logic [4:0] dest;
        logic       ld;
    } rec_t;

    rec_t r_ex;
    rec_t r_mem;
    rec_t r_wb;
    rec_t w_ex_next;

    logic [CNT_W-1:0] r_cnt;

    logic w_ex_rs;
    logic w_ex_rt;
    logic w_mem_rs;
    logic w_mem_rt;
    logic w_wb_rs;
    logic w_wb_rt;
    logic w_hazard;
    logic w_stall;
    logic w_bubble;
    logic w_unused_wb_ld;

    // True when a record will write the register this source operand reads.
    // $0 is hard-wired to zero, so it never produces a dependency.
    function automatic logic f_match(input rec_t rec, input logic [4:0] src,
                                     input logic use_src);
        return rec.v & rec.we & (rec.dest != 5'd0) & (rec.dest == src) & use_src;
    endfunction

    // Youngest producer wins: EX over MEM over WB.
    function automatic logic [1:0] f_sel(input logic m_ex, input logic m_mem,
                                         input logic m_wb);
        logic [1:0] sel;
        sel = FWD_RF;
        if (m_ex) begin
            sel = FWD_MEM;
        end else if (m_mem) begin
            sel = FWD_WB;
        end else if (m_wb) begin
            sel = FWD_WBV;
        end
        return sel;
    endfunction

    assign w_ex_rs  = f_match(r_ex,  i_id_rs, i_id_use_rs);
    assign w_ex_rt  = f_match(r_ex,  i_id_rt, i_id_use_rt);
    assign w_mem_rs = f_match(r_mem, i_id_rs, i_id_use_rs);
    assign w_mem_rt = f_match(r_mem, i_id_rt, i_id_use_rt);
    assign w_wb_rs  = f_match(r_wb,  i_id_rs, i_id_use_rs);
    assign w_wb_rt  = f_match(r_wb,  i_id_rt, i_id_use_rt);

    // Hazard detection: with bypassing only a load in EX blocks the consumer;
    // without it any pending producer does, including WB because the register
    // file is written on the edge that closes WB while reads are combinational.
    always_comb begin
        w_hazard = 1'b0;
        if (FORWARD != 0) begin
            w_hazard = r_ex.ld & (w_ex_rs | w_ex_rt);
        end else begin
            w_hazard = w_ex_rs | w_ex_rt | w_mem_rs | w_mem_rt | w_wb_rs | w_wb_rt;
        end
    end

    // A redirect kills the ID instruction, so there is nothing left to hold.
    assign w_stall  = i_id_valid & w_hazard & ~i_flush;
    assign w_bubble = w_stall | i_flush | ~i_id_valid;

    assign o_stall     = w_stall;
    assign o_bubble    = w_bubble;
    assign o_stall_cnt = r_cnt;

    // Forward selects for the ID instruction; registered by ID/EX downstream.
    always_comb begin
        o_fwd_a = FWD_RF;
        o_fwd_b = FWD_RF;
        if (FORWARD != 0) begin
            o_fwd_a = f_sel(w_ex_rs, w_mem_rs, w_wb_rs);
            o_fwd_b = f_sel(w_ex_rt, w_mem_rt, w_wb_rt);
        end
    end

    // Next EX record: a bubble enters as an all-zero record.
    always_comb begin
        w_ex_next = '0;
        if (!w_bubble) begin
            w_ex_next = rec_t'{
                v:    1'b1,
                we:   i_id_reg_write,
                dest: i_id_dest,
                ld:   i_id_is_load
            };
        end
    end

    // Record pipeline advances unconditionally; MEM and WB drain during stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex  <= '0;
            r_mem <= '0;
            r_wb  <= '0;
        end else begin
            r_wb  <= r_mem;
            r_mem <= r_ex;
            r_ex  <= w_ex_next;
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_stall && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // The load flag is irrelevant once an instruction has reached WB.
    assign w_unused_wb_ld = r_wb.ld;

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Bench for id_hazard_ctrl: three instances (forwarding, full interlock,
// forwarding with a 4-bit counter) share one stimulus stream and are checked
// every cycle against a model of the in-flight window, plus directed checks.
module tb_id_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       id_valid = 1'b0;
    logic [4:0] id_rs = '0;
    logic [4:0] id_rt = '0;
    logic       id_use_rs = 1'b0;
    logic       id_use_rt = 1'b0;
    logic       id_reg_write = 1'b0;
    logic [4:0] id_dest = '0;
    logic       id_is_load = 1'b0;
    logic       flush = 1'b0;

    logic [2:0]  st_v;
    logic [2:0]  bb_v;
    logic [5:0]  fa_v;
    logic [5:0]  fb_v;
    logic [15:0] cnt0;
    logic [15:0] cnt1;
    logic [3:0]  cnt2;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    always #5 clk = ~clk;

    id_hazard_ctrl #(.FORWARD(1), .CNT_W(16)) u_fwd (
        .clk(clk), .rst_n(rst_n), .i_id_valid(id_valid), .i_id_rs(id_rs),
        .i_id_rt(id_rt), .i_id_use_rs(id_use_rs), .i_id_use_rt(id_use_rt),
        .i_id_reg_write(id_reg_write), .i_id_dest(id_dest), .i_id_is_load(id_is_load),
        .i_flush(flush), .o_stall(st_v[0]), .o_bubble(bb_v[0]), .o_fwd_a(fa_v[1:0]),
        .o_fwd_b(fb_v[1:0]), .o_stall_cnt(cnt0)
    );

    id_hazard_ctrl #(.FORWARD(0), .CNT_W(16)) u_ilk (
        .clk(clk), .rst_n(rst_n), .i_id_valid(id_valid), .i_id_rs(id_rs),
        .i_id_rt(id_rt), .i_id_use_rs(id_use_rs), .i_id_use_rt(id_use_rt),
        .i_id_reg_write(id_reg_write), .i_id_dest(id_dest), .i_id_is_load(id_is_load),
        .i_flush(flush), .o_stall(st_v[1]), .o_bubble(bb_v[1]), .o_fwd_a(fa_v[3:2]),
        .o_fwd_b(fb_v[3:2]), .o_stall_cnt(cnt1)
    );

    id_hazard_ctrl #(.FORWARD(1), .CNT_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .i_id_valid(id_valid), .i_id_rs(id_rs),
        .i_id_rt(id_rt), .i_id_use_rs(id_use_rs), .i_id_use_rt(id_use_rt),
        .i_id_reg_write(id_reg_write), .i_id_dest(id_dest), .i_id_is_load(id_is_load),
        .i_flush(flush), .o_stall(st_v[2]), .o_bubble(bb_v[2]), .o_fwd_a(fa_v[5:4]),
        .o_fwd_b(fb_v[5:4]), .o_stall_cnt(cnt2)
    );

    // ---------------- reference model ----------------
    typedef struct {
        bit       v;
        bit       we;
        bit [4:0] dest;
        bit       ld;
    } slot_t;

    // win[i][k]: instruction k+1 stages past ID (0=EX, 1=MEM, 2=WB).
    slot_t       win[3][3];
    int unsigned mcnt[3];
    bit          m_fwd[3] = '{1'b1, 1'b0, 1'b1};
    int unsigned m_max[3] = '{65535, 65535, 15};

    // Last observed values, for directed checks.
    logic [31:0] obs_st[3];
    logic [31:0] obs_bb[3];
    logic [31:0] obs_fa[3];
    logic [31:0] obs_fb[3];
    logic [31:0] obs_cnt[3];
    bit          exp_bub[3];
    bit          exp_st[3];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit hit(input slot_t s, input bit [4:0] src, input bit use_src);
        return s.v && s.we && s.dest != 0 && s.dest == src && use_src;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 3; i++) begin
            mcnt[i] = 0;
            for (int k = 0; k < 3; k++) win[i][k] = '{0, 0, 0, 0};
        end
    endtask

    task automatic model_eval(input int i, output bit st, output bit bub,
                              output bit [1:0] fa, output bit [1:0] fb);
        bit raw;
        raw = 0;
        fa  = 0;
        fb  = 0;
        for (int k = 0; k < 3; k++) begin
            if (hit(win[i][k], id_rs, id_use_rs) || hit(win[i][k], id_rt, id_use_rt)) begin
                if (!m_fwd[i]) raw = 1;
                else if (k == 0 && win[i][k].ld) raw = 1;
            end
        end
        // Scan oldest to youngest so the youngest producer overwrites.
        for (int k = 2; k >= 0; k--) begin
            if (hit(win[i][k], id_rs, id_use_rs)) fa = 2'(k + 1);
            if (hit(win[i][k], id_rt, id_use_rt)) fb = 2'(k + 1);
        end
        if (!m_fwd[i]) begin
            fa = 0;
            fb = 0;
        end
        st  = raw && id_valid && !flush;
        bub = st || flush || !id_valid;
    endtask

    task automatic model_advance(input int i);
        win[i][2] = win[i][1];
        win[i][1] = win[i][0];
        if (exp_bub[i]) win[i][0] = '{0, 0, 0, 0};
        else win[i][0] = '{1, id_reg_write, id_dest, id_is_load};
        if (exp_st[i] && mcnt[i] < m_max[i]) mcnt[i]++;
    endtask

    function automatic logic [31:0] g_cnt(input int i);
        case (i)
            0:       return 32'(cnt0);
            1:       return 32'(cnt1);
            default: return 32'(cnt2);
        endcase
    endfunction

    task automatic drive(input bit v, input bit [4:0] rs, input bit [4:0] rt, input bit urs,
                         input bit urt, input bit we, input bit [4:0] dest, input bit ld,
                         input bit fl);
        id_valid     = v;
        id_rs        = rs;
        id_rt        = rt;
        id_use_rs    = urs;
        id_use_rt    = urt;
        id_reg_write = we;
        id_dest      = dest;
        id_is_load   = ld;
        flush        = fl;
    endtask

    // One cycle: drive, compare all instances against the model, clock.
    task automatic step(input bit v, input bit [4:0] rs, input bit [4:0] rt, input bit urs,
                        input bit urt, input bit we, input bit [4:0] dest, input bit ld,
                        input bit fl);
        bit       st;
        bit       bub;
        bit [1:0] fa;
        bit [1:0] fb;
        drive(v, rs, rt, urs, urt, we, dest, ld, fl);
        #3;
        for (int i = 0; i < 3; i++) begin
            model_eval(i, st, bub, fa, fb);
            exp_st[i]  = st;
            exp_bub[i] = bub;
            obs_st[i]  = 32'(st_v[i]);
            obs_bb[i]  = 32'(bb_v[i]);
            obs_fa[i]  = 32'(fa_v[2*i +: 2]);
            obs_fb[i]  = 32'(fb_v[2*i +: 2]);
            obs_cnt[i] = g_cnt(i);
            check($sformatf("stall%0d", i), obs_st[i], 32'(st));
            check($sformatf("bubble%0d", i), obs_bb[i], 32'(bub));
            check($sformatf("fwd_a%0d", i), obs_fa[i], 32'(fa));
            check($sformatf("fwd_b%0d", i), obs_fb[i], 32'(fb));
            check($sformatf("cnt%0d", i), obs_cnt[i], mcnt[i]);
        end
        @(posedge clk);
        for (int i = 0; i < 3; i++) model_advance(i);
        #1;
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    int unsigned base1;

    initial begin
        model_clear();
        // Reset with random inputs applied.
        #1 rst_n = 1'b0;
        drive(1, 5'($urandom), 5'($urandom), 1, 1, 1, 5'($urandom), 1, 0);
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_stall%0d", i), 32'(st_v[i]), 0);
            check($sformatf("rst_fwd_a%0d", i), 32'(fa_v[2*i +: 2]), 0);
            check($sformatf("rst_fwd_b%0d", i), 32'(fb_v[2*i +: 2]), 0);
            check($sformatf("rst_cnt%0d", i), g_cnt(i), 0);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Idle bubble stream.
        idle(3);
        check("idle_bubble", obs_bb[0], 1);
        check("idle_stall", obs_st[0], 0);

        // Load-use with forwarding: one stall cycle, then bypass from MEM/WB.
        step(1, 0, 0, 0, 0, 1, 8, 1, 0);
        step(1, 8, 0, 1, 0, 1, 10, 0, 0);
        check("lu_stall", obs_st[0], 1);
        check("lu_bubble", obs_bb[0], 1);
        step(1, 8, 0, 1, 0, 1, 10, 0, 0);
        check("lu_release", obs_st[0], 0);
        check("lu_fwd_a", obs_fa[0], 2);
        check("lu_cnt", obs_cnt[0], 1);

        // ALU back-to-back with forwarding.
        idle(3);
        step(1, 0, 0, 0, 0, 1, 5, 0, 0);
        step(1, 5, 5, 1, 1, 1, 6, 0, 0);
        check("alu_stall", obs_st[0], 0);
        check("alu_fwd_a1", obs_fa[0], 1);
        check("alu_fwd_b1", obs_fb[0], 1);
        step(1, 5, 5, 1, 1, 1, 6, 0, 0);
        check("alu_fwd_a2", obs_fa[0], 2);
        step(1, 5, 5, 1, 1, 1, 6, 0, 0);
        check("alu_fwd_a3", obs_fa[0], 3);

        // Full interlock: 3-cycle then 2-cycle stall.
        idle(3);
        base1 = mcnt[1];
        step(1, 0, 0, 0, 0, 1, 9, 0, 0);
        for (int j = 0; j < 4; j++) begin
            step(1, 0, 9, 0, 1, 1, 11, 0, 0);
            check($sformatf("ilk3_stall_%0d", j), obs_st[1], (j < 3) ? 1 : 0);
        end
        idle(3);
        step(1, 0, 0, 0, 0, 1, 9, 0, 0);
        step(1, 1, 2, 1, 1, 1, 12, 0, 0);
        for (int j = 0; j < 3; j++) begin
            step(1, 0, 9, 0, 1, 1, 11, 0, 0);
            check($sformatf("ilk2_stall_%0d", j), obs_st[1], (j < 2) ? 1 : 0);
        end
        idle(1);
        check("ilk_cnt", obs_cnt[1], base1 + 5);

        // $0 never creates a dependency.
        idle(3);
        step(1, 0, 0, 0, 0, 1, 0, 0, 0);
        step(1, 0, 0, 1, 0, 1, 13, 0, 0);
        check("r0_stall_fwd", obs_st[0], 0);
        check("r0_stall_ilk", obs_st[1], 0);
        check("r0_fwd_a", obs_fa[0], 0);

        // Flush beats a load-use stall and kills the incoming EX record.
        idle(3);
        step(1, 0, 0, 0, 0, 1, 4, 1, 0);
        step(1, 4, 0, 1, 0, 1, 7, 0, 1);
        check("fl_stall", obs_st[0], 0);
        check("fl_bubble", obs_bb[0], 1);
        step(1, 7, 0, 1, 0, 0, 0, 0, 0);
        check("fl_ex_clear", obs_fa[0], 0);

        // Saturation of the 4-bit counter, then reset mid-stall.
        idle(3);
        for (int j = 0; j < 41; j++) step(1, 8, 0, 1, 0, 1, 8, 1, 0);
        check("sat_cnt", obs_cnt[2], 15);
        drive(1, 8, 0, 1, 0, 1, 8, 1, 0);
        #3;
        check("pre_rst_stall", 32'(st_v[0]), 1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_stall0", 32'(st_v[0]), 0);
        check("rst_mid_stall1", 32'(st_v[1]), 0);
        check("rst_mid_cnt2", g_cnt(2), 0);
        model_clear();
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Random traffic over a small register set so hazards are frequent.
        for (int j = 0; j < 400; j++) begin
            step(($urandom_range(0, 7) != 0), 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), 1'($urandom),
                 5'($urandom_range(0, 7)), 1'($urandom), ($urandom_range(0, 9) == 0));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
